mem_stage_lsu: RTL

Memory-stage load/store unit, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address and the rs2 value as store data. It runs a request/grant/response handshake with data memory and aligns and extends load data. It then presents one registered write-back beat per instruction to the WB stage. Non-memory instructions pass through with one cycle of latency, and the unit stalls execute while a memory access is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 22 ++
 rtl/mem_stage_lsu_if.sv | 16 +
 rtl/mem_stage_lsu_load_align.sv | 24 ++
 rtl/mem_stage_lsu.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and decode helpers for the memory-stage load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

    // Unsupported width codes are folded into the misaligned path so they never reach memory.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign/zero-extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'(rdata >> {addr, 3'b000});
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_BU:   data = {24'h0, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_HU:   data = {16'h0, h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues data-memory accesses, aligns load data and emits one
// registered write-back beat per accepted instruction.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    mem_stage_lsu_if.master mem,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic            wb_misalign
);
    lsu_state_t  state, state_nxt;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        reg_write_q;
    logic        mem_op, mis;
    logic [31:0] lane_wdata, load_data;
    logic [3:0]  lane_wstrb;

    assign ex_ready = (state == IDLE);
    assign mem_op   = ex_is_load | ex_is_store;
    assign mis      = is_misaligned(ex_funct3, ex_alu_out[1:0]);

    always_comb begin
        lane_wdata = ex_store_data;
        lane_wstrb = 4'b1111;
        case (ex_funct3)
            F3_B, F3_BU: begin
                lane_wdata = {4{ex_store_data[7:0]}};
                lane_wstrb = 4'b0001 << ex_alu_out[1:0];
            end
            F3_H, F3_HU: begin
                lane_wdata = {2{ex_store_data[15:0]}};
                lane_wstrb = ex_alu_out[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ex_valid) state_nxt = (mem_op && !mis) ? REQ : DONE;
            REQ:  if (mem.mem_gnt) state_nxt = mem.mem_we ? DONE : RESP;
            RESP: if (mem.mem_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    load_align u_align (
        .rdata  (mem.mem_rdata),
        .addr   (addr_lo_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr_lo_q     <= '0;
            funct3_q      <= '0;
            reg_write_q   <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_we         <= 1'b0;
            wb_misalign   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem.mem_req <= (state_nxt == REQ);
            wb_valid    <= (state_nxt == DONE);
            if (state == IDLE && ex_valid) begin
                addr_lo_q   <= ex_alu_out[1:0];
                funct3_q    <= ex_funct3;
                reg_write_q <= ex_reg_write;
                wb_rd       <= ex_rd;
                wb_data     <= ex_alu_out;
                wb_we       <= ex_reg_write & ~mem_op;
                wb_misalign <= mem_op & mis;
                if (state_nxt == REQ) begin
                    mem.mem_we    <= ex_is_store;
                    mem.mem_addr  <= {ex_alu_out[XLEN-1:2], 2'b00};
                    mem.mem_wdata <= lane_wdata;
                    mem.mem_wstrb <= ex_is_store ? lane_wstrb : 4'b0000;
                end
            end
            // Load write enable is deferred until the data actually arrives.
            if (state == RESP && mem.mem_rvalid) begin
                wb_data <= load_data;
                wb_we   <= reg_write_q;
            end
        end
    end
endmodule
